sel_pipe_mux: RTL and testbench



---
 rtl/sel_pipe_mux_pkg.sv | 25 ++
 rtl/sel_pipe_mux_skid.sv | 65 ++++++
 rtl/sel_pipe_mux.sv | 108 ++++++++++
 tb/tb_sel_pipe_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_pipe_mux_pkg.sv
// Shared definitions for sel_pipe_mux: buffer state encoding, entry layout and default parameters.
package sel_pipe_mux_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_IN = 8;
    localparam int DEF_SEL_W  = $clog2(DEF_NUM_IN);

    typedef logic [1:0] buf_state_t;

    localparam buf_state_t ST_EMPTY = 2'd0;
    localparam buf_state_t ST_ONE   = 2'd1;
    localparam buf_state_t ST_TWO   = 2'd2;

    // Reference entry layout at default widths; the top builds the same field order at its own widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SEL_W-1:0] sel;
        logic                 err;
    } entry_t;

    function automatic int entry_bits(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/sel_pipe_mux_skid.sv
// Generic two-entry valid/ready skid buffer; in_ready depends only on the state register.
// Handshake: a beat moves on any cycle where valid && ready; the payload is stable while valid is held without ready.
module sel_pipe_mux_skid
    import sel_pipe_mux_pkg::*;
#(
    parameter int EW = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_data,
    output buf_state_t    state
);

    logic [EW-1:0] out_q;
    logic [EW-1:0] skid_q;
    logic          acc;
    logic          pop;

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_q;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        out_q <= in_data;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && !pop) begin
                        skid_q <= in_data;
                        state  <= ST_TWO;
                    end else if (acc && pop) begin
                        out_q <= in_data;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Older entry leaves first, so the skid entry moves up to the output register.
                    if (pop) begin
                        out_q <= skid_q;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sel_pipe_mux.sv
// Registered N-way operand selector feeding a two-entry skid buffer, with out-of-range select detection.
// Optional sticky error flag enabled by defining SEL_PIPE_MUX_ERR_EN.
module sel_pipe_mux
    import sel_pipe_mux_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               NUM_IN      = DEF_NUM_IN,
    parameter int               SEL_W       = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_ld,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sticky,
    input  logic                    err_clr,
    output buf_state_t              dbg_state
);

    localparam int EW = entry_bits(WIDTH, SEL_W);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } pipe_entry_t;

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_eff;
    logic             err_eff;
    logic [WIDTH-1:0] mux_data;
    logic             acc;
    pipe_entry_t      in_e;
    pipe_entry_t      out_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else if (sel_ld) begin
            sel_q <= sel;
        end
    end

    // A same-cycle load steers the transfer offered in that cycle.
    assign sel_eff = sel_ld ? sel : sel_q;
    assign err_eff = (32'(sel_eff) >= 32'(NUM_IN));
    assign acc     = in_valid && in_ready;

    always_comb begin
        mux_data = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_eff == SEL_W'(k)) begin
                mux_data = in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_e = '{data: mux_data, sel: sel_eff, err: err_eff};

    sel_pipe_mux_skid #(
        .EW(EW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_e),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_e),
        .state    (dbg_state)
    );

    assign out_data = out_e.data;
    assign out_sel  = out_e.sel;
    assign out_err  = out_e.err;

`ifdef SEL_PIPE_MUX_ERR_EN
    logic err_q;

    // Set has priority so an error arriving alongside a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (acc && err_eff) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_sticky = err_q;
`else
    logic unused_err;

    assign unused_err = err_clr ^ acc;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed bench for sel_pipe_mux: vector table for single transfers plus hand-written multi-cycle sequences.
module tb_sel_pipe_mux;

    localparam int W = 32;

`ifdef SEL_PIPE_MUX_ERR_EN
    localparam logic EXP_STICKY = 1'b1;
`else
    localparam logic EXP_STICKY = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance: NUM_IN = 8
    logic [8*W-1:0] in_flat;
    logic [2:0]     sel;
    logic           sel_ld, in_valid, in_ready, out_valid, out_ready, out_err;
    logic           err_sticky, err_clr;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic [1:0]     dbg_state;

    // second instance: NUM_IN = 5, non-zero default
    logic [5*W-1:0] in_flat5;
    logic [2:0]     sel5;
    logic           sel_ld5, in_valid5, in_ready5, out_valid5, out_ready5, out_err5;
    logic           err_sticky5, err_clr5;
    logic [W-1:0]   out_data5;
    logic [2:0]     out_sel5;
    logic [1:0]     dbg_state5;

    sel_pipe_mux #(.WIDTH(W), .NUM_IN(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel), .sel_ld(sel_ld),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .err_sticky(err_sticky), .err_clr(err_clr), .dbg_state(dbg_state)
    );

    sel_pipe_mux #(.WIDTH(W), .NUM_IN(5), .DEFAULT_VAL(32'hDEFA_0017)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat5), .sel(sel5), .sel_ld(sel_ld5),
        .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5), .out_sel(out_sel5),
        .out_err(out_err5), .out_valid(out_valid5), .out_ready(out_ready5),
        .err_sticky(err_sticky5), .err_clr(err_clr5), .dbg_state(dbg_state5)
    );

    // scoreboard
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic fill_slots();
        for (int k = 0; k < 8; k++) in_flat[k*W +: W] = 32'h0BAD_0000 | k;
    endtask

    task automatic set_slot(input int k, input logic [W-1:0] v);
        in_flat[k*W +: W] = v;
    endtask

    // Offer one transfer, then scramble inputs so only the accepted sample can reach the output.
    task automatic xfer(input logic ld, input logic [2:0] s, input int slot, input logic [W-1:0] word);
        @(posedge clk); #1;
        fill_slots();
        set_slot(slot, word);
        sel = s; sel_ld = ld; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; sel_ld = 1'b0; sel = ~s;
        in_flat = ~in_flat;
        @(negedge clk);
    endtask

    typedef struct {
        logic         ld;
        logic [2:0]   sel;
        int           slot;
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
        logic [2:0]   exp_sel;
    } vec_t;

    vec_t vecs[5];

    initial begin
        in_flat = '0; sel = '0; sel_ld = 0; in_valid = 0; out_ready = 0; err_clr = 0;
        in_flat5 = '0; sel5 = '0; sel_ld5 = 0; in_valid5 = 0; out_ready5 = 0; err_clr5 = 0;

        // sel_q persists between vectors: 0 -> 3 -> 3 -> 0 -> 7 -> 7
        vecs[0] = '{1'b1, 3'd3, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd3};
        vecs[1] = '{1'b0, 3'd7, 3, 32'h1234_5678, 32'h1234_5678, 3'd3};
        vecs[2] = '{1'b1, 3'd0, 0, 32'h0000_0001, 32'h0000_0001, 3'd0};
        vecs[3] = '{1'b1, 3'd7, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7};
        vecs[4] = '{1'b0, 3'd2, 7, 32'h8000_0000, 32'h8000_0000, 3'd7};

        // reset values
        #12;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_data", out_data, 0);
        check("rst out_sel", out_sel, 0);
        check("rst out_err", out_err, 0);
        check("rst err_sticky", err_sticky, 0);
        check("rst5 out_valid", out_valid5, 0);
        check("rst5 in_ready", in_ready5, 1);
        check("rst5 err_sticky", err_sticky5, 0);
        @(negedge clk); rst_n = 1'b1;

        // table-driven single transfers
        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i].ld, vecs[i].sel, vecs[i].slot, vecs[i].word);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d out_sel", i), out_sel, vecs[i].exp_sel);
            check($sformatf("vec%0d out_err", i), out_err, 0);
        end

        // sel_ld alone only updates sel_q
        @(posedge clk); #1;
        sel_ld = 1'b1; sel = 3'd2; in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        sel_ld = 1'b0;
        @(negedge clk);
        check("ld_only out_valid", out_valid, 0);
        xfer(1'b0, 3'd6, 2, 32'h2222_0002);
        check("ld_only data", out_data, 32'h2222_0002);
        check("ld_only sel", out_sel, 2);

        // same-cycle load, then sticky select
        xfer(1'b1, 3'd5, 5, 32'h5555_0005);
        check("same_ld data", out_data, 32'h5555_0005);
        check("same_ld sel", out_sel, 5);
        xfer(1'b0, 3'd1, 5, 32'h5555_0006);
        check("after_ld data", out_data, 32'h5555_0006);
        check("after_ld sel", out_sel, 5);

        // back-to-back stream, sel cycling 0..7
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) in_flat[k*W +: W] = 32'h5000_0000 | (k * 32'h11);
        out_ready = 1'b1;
        sel_ld = 1'b1; sel = 3'd0; in_valid = 1'b1;
        exp_q.push_back(32'h5000_0000);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8) begin
                sel = 3'(k);
                exp_q.push_back(32'h5000_0000 | (k * 32'h11));
            end else begin
                in_valid = 1'b0; sel_ld = 1'b0;
            end
            @(negedge clk);
            check($sformatf("stream%0d valid", k - 1), out_valid, 1);
            check($sformatf("stream%0d data", k - 1), out_data, exp_q.pop_front());
        end
        @(negedge clk);
        check("stream drained", out_valid, 0);

        // fill both entries with out_ready low, then drain
        @(posedge clk); #1;
        fill_slots();
        out_ready = 1'b0; sel_ld = 1'b1; sel = 3'd1; set_slot(1, 32'h11); in_valid = 1'b1;
        @(posedge clk); #1;
        sel_ld = 1'b0; set_slot(1, 32'h22);
        @(negedge clk);
        check("skid first data", out_data, 32'h11);
        check("skid first in_ready", in_ready, 1);
        @(posedge clk); #1;
        set_slot(1, 32'h33);
        @(negedge clk);
        check("skid full in_ready", in_ready, 0);
        check("skid full state", dbg_state, 2);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("skid hold data", out_data, 32'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("skid second data", out_data, 32'h22);
        check("skid second valid", out_valid, 1);
        check("skid in_ready back", in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("skid empty", out_valid, 0);

        // asynchronous reset while holding two entries
        @(posedge clk); #1;
        fill_slots();
        out_ready = 1'b0; sel_ld = 1'b1; sel = 3'd4; set_slot(4, 32'hAAAA_0004); in_valid = 1'b1;
        @(posedge clk); #1;
        sel_ld = 1'b0; set_slot(4, 32'hBBBB_0004);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst state", dbg_state, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", out_valid, 0);
        check("mid_rst in_ready", in_ready, 1);
        check("mid_rst out_data", out_data, 0);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst out_valid", out_valid, 0);
        xfer(1'b0, 3'd6, 0, 32'h7777_0000);
        check("post_rst data", out_data, 32'h7777_0000);
        check("post_rst sel", out_sel, 0);

        // out-of-range select on the NUM_IN=5 instance
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) in_flat5[k*W +: W] = 32'h0C0C_0000 | k;
        sel_ld5 = 1'b1; sel5 = 3'd6; in_valid5 = 1'b1; out_ready5 = 1'b1;
        @(posedge clk); #1;
        sel_ld5 = 1'b0; in_valid5 = 1'b0;
        @(negedge clk);
        check("oor6 valid", out_valid5, 1);
        check("oor6 data", out_data5, 32'hDEFA_0017);
        check("oor6 err", out_err5, 1);
        check("oor6 sel", out_sel5, 6);
        check("oor6 sticky", err_sticky5, EXP_STICKY);
        @(negedge clk);
        check("oor6 popped", out_valid5, 0);
        check("sticky held", err_sticky5, EXP_STICKY);
        @(posedge clk); #1;
        sel_ld5 = 1'b1; sel5 = 3'd4; in_valid5 = 1'b1;
        @(posedge clk); #1;
        sel_ld5 = 1'b0; in_valid5 = 1'b0;
        @(negedge clk);
        check("edge4 data", out_data5, 32'h0C0C_0004);
        check("edge4 err", out_err5, 0);
        check("edge4 sticky", err_sticky5, EXP_STICKY);
        @(posedge clk); #1;
        err_clr5 = 1'b1;
        @(posedge clk); #1;
        err_clr5 = 1'b0;
        @(negedge clk);
        check("sticky cleared", err_sticky5, 0);
        @(posedge clk); #1;
        err_clr5 = 1'b1; sel_ld5 = 1'b1; sel5 = 3'd5; in_valid5 = 1'b1;
        @(posedge clk); #1;
        err_clr5 = 1'b0; sel_ld5 = 1'b0; in_valid5 = 1'b0;
        @(negedge clk);
        check("oor5 data", out_data5, 32'hDEFA_0017);
        check("oor5 err", out_err5, 1);
        check("set beats clr", err_sticky5, EXP_STICKY);
        @(posedge clk); #1;
        err_clr5 = 1'b1;
        @(posedge clk); #1;
        err_clr5 = 1'b0;
        @(negedge clk);
        check("sticky cleared again", err_sticky5, 0);
        check("main sticky idle", err_sticky, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
